// File: rtl/exe_muldiv_seq_pkg.sv
// Shared definitions for the RV64M multi-cycle multiply/divide sequencer:
// funct3 encodings, FSM states and special-case result constants.
package muldiv_pkg;

   localparam int MD_XLEN = 64;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [MD_XLEN-1:0] DIV0_QUOT   = {MD_XLEN{1'b1}};
   localparam logic [MD_XLEN-1:0] OVF_REM     = {MD_XLEN{1'b0}};
   localparam logic [MD_XLEN-1:0] ILLEGAL_RES = {MD_XLEN{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } md_state_e;

endpackage

// File: rtl/exe_muldiv_seq_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic [XLEN-1:0] rem,
   input  logic            bit_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   logic [XLEN:0] shifted_s;

   // The shifted remainder needs one extra bit, the kept difference never does
   always_comb begin
      shifted_s = {rem, bit_in};
      q_bit     = (shifted_s >= {1'b0, divisor});
      if (q_bit) begin
         rem_next = shifted_s[XLEN-1:0] - divisor;
      end else begin
         rem_next = shifted_s[XLEN-1:0];
      end
   end

endmodule

// File: rtl/exe_muldiv_seq.sv
// RV64M sequencer: one-cycle registered multiply, restoring divide with one
// quotient bit per cycle, sign fix-up, and a one-cycle done pulse.
module exe_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      func3,
   input  logic            is_word,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int HW = XLEN / 2;
   localparam int CW = $clog2(XLEN) + 1;

   md_state_e       state_r, state_nxt_s;
   logic [2:0]      func3_r;
   logic            is_word_r;
   logic            neg_a_r, neg_b_r;
   logic [XLEN-1:0] a_r, b_r, quo_r, rem_r, result_r;
   logic [CW-1:0]   cnt_r;

   logic            sgn_a_s, sgn_b_s, is_div_s, neg_a_s, neg_b_s;
   logic            div0_s, ovf_s, illegal_s, special_s;
   logic [XLEN-1:0] ext_a_s, ext_b_s, mag_a_s, mag_b_s, min_neg_s, spec_val_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] mul_res_s, q_fix_s, r_fix_s, fix_res_s, rem_nxt_s;
   logic            q_bit_s;

   function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic w);
      if (w) begin
         fit_word = {{HW{v[HW-1]}}, v[HW-1:0]};
      end else begin
         fit_word = v;
      end
   endfunction

   // Operand extension, magnitudes and special-case detection at capture
   always_comb begin
      sgn_a_s  = (func3 != F3_MULHU) && (func3 != F3_DIVU) && (func3 != F3_REMU);
      sgn_b_s  = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
      is_div_s = func3[2];
      if (is_word) begin
         ext_a_s   = sgn_a_s ? {{HW{op_a[HW-1]}}, op_a[HW-1:0]} : {{HW{1'b0}}, op_a[HW-1:0]};
         ext_b_s   = sgn_b_s ? {{HW{op_b[HW-1]}}, op_b[HW-1:0]} : {{HW{1'b0}}, op_b[HW-1:0]};
         min_neg_s = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
      end else begin
         ext_a_s   = op_a;
         ext_b_s   = op_b;
         min_neg_s = {1'b1, {(XLEN-1){1'b0}}};
      end
      neg_a_s   = sgn_a_s & ext_a_s[XLEN-1];
      neg_b_s   = sgn_b_s & ext_b_s[XLEN-1];
      mag_a_s   = neg_a_s ? ({XLEN{1'b0}} - ext_a_s) : ext_a_s;
      mag_b_s   = neg_b_s ? ({XLEN{1'b0}} - ext_b_s) : ext_b_s;
      div0_s    = is_div_s & (ext_b_s == {XLEN{1'b0}});
      ovf_s     = is_div_s & sgn_b_s & (ext_a_s == min_neg_s) & (ext_b_s == {XLEN{1'b1}});
      illegal_s = is_word & ~is_div_s & (func3 != F3_MUL);
      special_s = div0_s | ovf_s | illegal_s;
      if (illegal_s) begin
         spec_val_s = ILLEGAL_RES;
      end else if (div0_s) begin
         spec_val_s = func3[1] ? ext_a_s : DIV0_QUOT;
      end else begin
         spec_val_s = func3[1] ? OVF_REM : ext_a_s;
      end
      spec_val_s = fit_word(spec_val_s, is_word);
   end

   // Product and sign fix-up on captured state
   always_comb begin
      prod_s    = {{XLEN{neg_a_r}}, a_r} * {{XLEN{neg_b_r}}, b_r};
      mul_res_s = fit_word((func3_r == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN], is_word_r);
      q_fix_s   = (neg_a_r ^ neg_b_r) ? ({XLEN{1'b0}} - quo_r) : quo_r;
      r_fix_s   = neg_a_r ? ({XLEN{1'b0}} - rem_r) : rem_r;
      fix_res_s = fit_word(func3_r[1] ? r_fix_s : q_fix_s, is_word_r);
   end

   div_step #(.XLEN(XLEN)) u_div_step (
      .rem      (rem_r),
      .bit_in   (quo_r[XLEN-1]),
      .divisor  (b_r),
      .rem_next (rem_nxt_s),
      .q_bit    (q_bit_s)
   );

   // Next-state decode; kill wins over every transition
   always_comb begin
      state_nxt_s = state_r;
      if (kill) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!start) begin
                  state_nxt_s = ST_IDLE;
               end else if (special_s) begin
                  state_nxt_s = ST_DONE;
               end else if (is_div_s) begin
                  state_nxt_s = ST_DIV;
               end else begin
                  state_nxt_s = ST_MUL;
               end
            end
            ST_MUL:  state_nxt_s = ST_DONE;
            ST_DIV:  state_nxt_s = (cnt_r == {{(CW-1){1'b0}}, 1'b1}) ? ST_FIX : ST_DIV;
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand capture, divide iteration and result load
   always_ff @(posedge clk) begin
      if (rst) begin
         func3_r   <= 3'd0;
         is_word_r <= 1'b0;
         neg_a_r   <= 1'b0;
         neg_b_r   <= 1'b0;
         a_r       <= {XLEN{1'b0}};
         b_r       <= {XLEN{1'b0}};
         quo_r     <= {XLEN{1'b0}};
         rem_r     <= {XLEN{1'b0}};
         cnt_r     <= {CW{1'b0}};
         result_r  <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start && !kill) begin
                  func3_r   <= func3;
                  is_word_r <= is_word;
                  neg_a_r   <= neg_a_s;
                  neg_b_r   <= neg_b_s;
                  a_r       <= ext_a_s;
                  b_r       <= is_div_s ? mag_b_s : ext_b_s;
                  quo_r     <= is_word ? {mag_a_s[HW-1:0], {HW{1'b0}}} : mag_a_s;
                  rem_r     <= {XLEN{1'b0}};
                  cnt_r     <= is_word ? CW'(HW) : CW'(XLEN);
                  if (special_s) begin
                     result_r <= spec_val_s;
                  end
               end
            end
            ST_MUL: begin
               if (!kill) begin
                  result_r <= mul_res_s;
               end
            end
            ST_DIV: begin
               if (!kill) begin
                  rem_r <= rem_nxt_s;
                  quo_r <= {quo_r[XLEN-2:0], q_bit_s};
                  cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
               end
            end
            ST_FIX: begin
               if (!kill) begin
                  result_r <= fix_res_s;
               end
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

   assign busy   = (state_r != ST_IDLE);
   assign done   = (state_r == ST_DONE);
   assign result = result_r;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Directed-vector bench for exe_muldiv_seq: results, done latency, busy,
// kill/start-ignore/reset behaviour against hand-computed values.
module tb_exe_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  func3;
   logic        is_word;
   logic [63:0] op_a, op_b;
   logic        kill;
   logic        busy, done;
   logic [63:0] result;

   int n_cmp = 0;
   int n_bad = 0;

   exe_muldiv_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .func3   (func3),
      .is_word (is_word),
      .op_a    (op_a),
      .op_b    (op_b),
      .kill    (kill),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one op, find the done cycle (bounded), check latency, result and busy
   task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int exp_cyc);
      int cyc;
      int k;
      int busy_low;
      cyc = -1;
      k = 1;
      busy_low = 0;
      @(negedge clk);
      func3 = f3; is_word = w; op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 0 && k <= 200) begin
         if (!busy) busy_low++;
         if (done) begin
            cyc = k;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      check_val({tag, " cycle"}, 64'(cyc), 64'(exp_cyc));
      check_val({tag, " result"}, result, exp_res);
      check_val({tag, " busy_low"}, 64'(busy_low), 64'd0);
      @(negedge clk);
      check_val({tag, " busy_after"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int dones;
      logic [63:0] prev;
      rst = 1'b1; start = 1'b0; kill = 1'b0; func3 = 3'd0; is_word = 1'b0;
      op_a = 64'd0; op_b = 64'd0;
      repeat (3) @(negedge clk);
      check_val("rst busy", {63'd0, busy}, 64'd0);
      check_val("rst done", {63'd0, done}, 64'd0);
      check_val("rst result", result, 64'd0);
      rst = 1'b0;

      run_op("MUL 3*-5",      3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 2);
      run_op("MULHU",         3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 2);
      run_op("MULH -1*-1",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
      run_op("MULHSU -1*2",   3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 2);
      run_op("MULW",          3'd0, 1'b1, 64'hAAAA_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
      run_op("DIV -7/2",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
      run_op("REM -7/2",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run_op("REMU 7/2",      3'd7, 1'b0, 64'd7, 64'd2, 64'd1, 66);
      run_op("REMU big",      3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 66);
      run_op("DIVU 5/0",      3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("REM 5/0",       3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      run_op("DIV ovf",       3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      run_op("DIVUW",         3'd5, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
      run_op("DIVW -20/3",    3'd4, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hDEAD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 34);
      run_op("REMW -20/3",    3'd6, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 34);
      run_op("REMUW x/0",     3'd7, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0000, 1);
      run_op("DIVW ovf",      3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      run_op("MULHW illegal", 3'd1, 1'b1, 64'd7, 64'd9, 64'd0, 1);
      run_op("MUL restore",   3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 2);

      // DIV with an ignored start in cycle 5, then kill in cycle 10
      prev = result;
      dones = 0;
      @(negedge clk);
      func3 = 3'd4; is_word = 1'b0; op_a = 64'd100; op_b = 64'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         if (done) dones++;
         if (c == 5) begin
            func3 = 3'd0; op_a = 64'd1; op_b = 64'd1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (c == 10) kill = 1'b1;
         @(negedge clk);
      end
      kill = 1'b0;
      check_val("kill busy", {63'd0, busy}, 64'd0);
      check_val("kill done", {63'd0, done}, 64'd0);
      check_val("kill result", result, prev);
      for (int c = 0; c < 70; c++) begin
         if (done || busy) dones++;
         @(negedge clk);
      end
      check_val("kill quiet", 64'(dones), 64'd0);

      // start together with kill in IDLE is not accepted
      func3 = 3'd0; op_a = 64'd2; op_b = 64'd2; start = 1'b1; kill = 1'b1;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      check_val("kill+start busy", {63'd0, busy}, 64'd0);

      // reset in cycle 20 of a DIV
      func3 = 3'd5; op_a = 64'd1000; op_b = 64'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 20; c++) @(negedge clk);
      check_val("pre-rst busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst busy", {63'd0, busy}, 64'd0);
      check_val("midrst done", {63'd0, done}, 64'd0);
      check_val("midrst result", result, 64'd0);
      run_op("DIVU post-rst", 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 66);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
